vga_capture: RTL and testbench

//   Receive side of the framebuffer video interface: consumes a 640x480@60 pixel stream
//   (hsync/vsync/data-enable/RGB888) qualified by the 25 MHz pixel enable. Writes the top-left
//   CAP_W x CAP_H window into a 15-bit framebuffer. Each pixel is packed {B[7:3],G[7:3],R[7:3]}.

---
 rtl/vga_capture.sv | 160 ++++++++++++++++
 tb/tb_vga_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// Captures the top-left window of a DE-delimited pixel stream into a 15-bit framebuffer and measures the active resolution.
// Latency: a write strobe follows its qualifying pixel sample by 1 clk; frame results appear 1 clk after the vsync fall.
// No backpressure: the video source is free-running, so every qualifying sample is written unconditionally.
module vga_capture #(
    parameter int CAP_W  = 240,
    parameter int CAP_H  = 160,
    parameter int ADDR_W = 16,
    parameter int EXP_H  = 640,
    parameter int EXP_V  = 480
) (
    input  logic              i_clock50,
    input  logic              i_reset_n,
    input  logic              i_ce25,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_dataEnable,
    input  logic [23:0]       i_RGBchannel,
    output logic              o_wren,
    output logic [ADDR_W-1:0] o_wraddr,
    output logic [14:0]       o_wrdata,
    output logic              o_frameDone,
    output logic              o_locked,
    output logic [9:0]        o_hActive,
    output logic [9:0]        o_vActive,
    output logic              o_error
);

    localparam logic [9:0]        CAP_W_L   = 10'(CAP_W);
    localparam logic [9:0]        CAP_H_L   = 10'(CAP_H);
    localparam logic [9:0]        EXP_H_L   = 10'(EXP_H);
    localparam logic [9:0]        EXP_V_L   = 10'(EXP_V);
    localparam logic [9:0]        CNT_MAX   = 10'd1023;
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(CAP_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VSYNC  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t            state;
    logic              prev_vsync;
    logic              prev_de;
    logic [9:0]        x_cnt;
    logic [9:0]        y_cnt;
    logic [9:0]        line_w;
    logic [ADDR_W-1:0] line_base;
    logic [1:0]        match_cnt;

    logic              vs_fall;
    logic              vs_rise;
    logic              de_fall;
    logic              line_end;
    logic [9:0]        y_inc;
    logic [9:0]        y_eof;
    logic [9:0]        w_eof;
    logic              frame_match;
    logic [1:0]        match_nxt;

    // hsync carries no addressing information and the low colour bits are dropped by the 5-bit packing
    logic unused_inputs;
    assign unused_inputs = ^{i_hsync, i_RGBchannel[18:16], i_RGBchannel[10:8], i_RGBchannel[2:0]};

    // Edge detection and end-of-frame figures; a line ending on the vsync-fall sample is folded in first
    always_comb begin
        vs_fall     = prev_vsync & ~i_vsync;
        vs_rise     = ~prev_vsync & i_vsync;
        de_fall     = prev_de & ~i_dataEnable;
        line_end    = (state == ST_ACTIVE) && de_fall;
        y_inc       = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 10'd1;
        y_eof       = line_end ? y_inc : y_cnt;
        w_eof       = line_end ? x_cnt : line_w;
        frame_match = (y_eof == EXP_V_L) && (w_eof == EXP_H_L);
        match_nxt   = 2'd0;
        if (frame_match) begin
            match_nxt = (match_cnt == 2'd2) ? 2'd2 : match_cnt + 2'd1;
        end
    end

    // Capture FSM: frame sync, pixel write-out, line/frame measurement and lock tracking
    always_ff @(posedge i_clock50 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            prev_vsync  <= 1'b1;
            prev_de     <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_w      <= '0;
            line_base   <= '0;
            match_cnt   <= '0;
            o_wren      <= 1'b0;
            o_wraddr    <= '0;
            o_wrdata    <= '0;
            o_frameDone <= 1'b0;
            o_locked    <= 1'b0;
            o_hActive   <= '0;
            o_vActive   <= '0;
            o_error     <= 1'b0;
        end else begin
            o_wren      <= 1'b0;
            o_frameDone <= 1'b0;
            if (i_ce25) begin
                prev_vsync <= i_vsync;
                prev_de    <= i_dataEnable;
                if (i_dataEnable && !i_vsync) begin
                    o_error <= 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (vs_fall) begin
                            state     <= ST_VSYNC;
                            x_cnt     <= '0;
                            y_cnt     <= '0;
                            line_base <= '0;
                        end
                    end
                    ST_VSYNC: begin
                        if (vs_rise) begin
                            state <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (i_dataEnable && i_vsync) begin
                            if ((x_cnt < CAP_W_L) && (y_cnt < CAP_H_L)) begin
                                o_wren   <= 1'b1;
                                o_wraddr <= line_base + ADDR_W'(x_cnt);
                                o_wrdata <= {i_RGBchannel[7:3], i_RGBchannel[15:11], i_RGBchannel[23:19]};
                            end
                            if (x_cnt != CNT_MAX) begin
                                x_cnt <= x_cnt + 10'd1;
                            end
                        end
                        if (de_fall) begin
                            y_cnt  <= y_inc;
                            line_w <= x_cnt;
                            x_cnt  <= '0;
                            if (y_cnt < CAP_H_L) begin
                                line_base <= line_base + LINE_STEP;
                            end
                        end
                        // frame end overrides the line-end counter updates made above
                        if (vs_fall) begin
                            state       <= ST_VSYNC;
                            o_vActive   <= y_eof;
                            o_hActive   <= w_eof;
                            o_frameDone <= 1'b1;
                            match_cnt   <= match_nxt;
                            o_locked    <= (match_nxt == 2'd2);
                            x_cnt       <= '0;
                            y_cnt       <= '0;
                            line_base   <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
`timescale 1ns/1ps
module tb_vga_capture;

    localparam int CAP_W  = 12;
    localparam int CAP_H  = 6;
    localparam int ADDR_W = 16;
    localparam int EXP_H  = 20;
    localparam int EXP_V  = 10;

    logic              i_clock50 = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_ce25 = 1'b0;
    logic              i_hsync = 1'b1;
    logic              i_vsync = 1'b1;
    logic              i_dataEnable = 1'b0;
    logic [23:0]       i_RGBchannel = '0;
    logic              o_wren;
    logic [ADDR_W-1:0] o_wraddr;
    logic [14:0]       o_wrdata;
    logic              o_frameDone;
    logic              o_locked;
    logic [9:0]        o_hActive;
    logic [9:0]        o_vActive;
    logic              o_error;

    vga_capture #(
        .CAP_W (CAP_W),
        .CAP_H (CAP_H),
        .ADDR_W(ADDR_W),
        .EXP_H (EXP_H),
        .EXP_V (EXP_V)
    ) dut (
        .i_clock50   (i_clock50),
        .i_reset_n   (i_reset_n),
        .i_ce25      (i_ce25),
        .i_hsync     (i_hsync),
        .i_vsync     (i_vsync),
        .i_dataEnable(i_dataEnable),
        .i_RGBchannel(i_RGBchannel),
        .o_wren      (o_wren),
        .o_wraddr    (o_wraddr),
        .o_wrdata    (o_wrdata),
        .o_frameDone (o_frameDone),
        .o_locked    (o_locked),
        .o_hActive   (o_hActive),
        .o_vActive   (o_vActive),
        .o_error     (o_error)
    );

    always #10 i_clock50 = ~i_clock50;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (frame/line level) ----------------
    int          exp_addr[$];
    logic [14:0] exp_data[$];
    int          exp_v[$];
    int          exp_h[$];
    bit          exp_lk[$];
    bit          seen_fall = 0;
    bit          in_frame  = 0;
    bit          err_exp   = 0;
    int          lock_cnt  = 0;
    int          lines_seen = 0;
    int          last_w    = 0;

    function automatic logic [14:0] pack(input logic [23:0] p);
        return {p[7:3], p[15:11], p[23:19]};
    endfunction

    task automatic model_vs_fall();
        bit match;
        if (in_frame) begin
            match    = (lines_seen == EXP_V) && (last_w == EXP_H);
            lock_cnt = match ? ((lock_cnt == 2) ? 2 : lock_cnt + 1) : 0;
            exp_v.push_back(lines_seen);
            exp_h.push_back(last_w);
            exp_lk.push_back(lock_cnt == 2);
        end
        seen_fall = 1;
        in_frame  = 0;
    endtask

    task automatic model_vs_rise();
        if (seen_fall && !in_frame) begin
            in_frame   = 1;
            lines_seen = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic samp(input bit vs, input bit de, input logic [23:0] rgb);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            @(posedge i_clock50); #1;
            i_ce25       = 1'b0;
            i_vsync      = 1'($urandom);
            i_dataEnable = 1'($urandom);
            i_hsync      = 1'($urandom);
            i_RGBchannel = 24'($urandom);
        end
        @(posedge i_clock50); #1;
        i_ce25       = 1'b1;
        i_vsync      = vs;
        i_dataEnable = de;
        i_hsync      = de ? 1'b1 : 1'($urandom);
        i_RGBchannel = rgb;
    endtask

    task automatic do_reset();
        @(posedge i_clock50); #1;
        i_ce25    = 1'b0;
        i_reset_n = 1'b0;
        exp_addr.delete(); exp_data.delete();
        exp_v.delete(); exp_h.delete(); exp_lk.delete();
        seen_fall = 0; in_frame = 0; err_exp = 0; lock_cnt = 0; last_w = 0;
        repeat (2) @(posedge i_clock50);
        @(negedge i_clock50);
        chk("rst_wren",   32'(o_wren), 0);
        chk("rst_wraddr", 32'(o_wraddr), 0);
        chk("rst_wrdata", 32'(o_wrdata), 0);
        chk("rst_fdone",  32'(o_frameDone), 0);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_hact",   32'(o_hActive), 0);
        chk("rst_vact",   32'(o_vActive), 0);
        chk("rst_error",  32'(o_error), 0);
        @(posedge i_clock50); #1;
        i_reset_n = 1'b1;
    endtask

    // One frame: vsync pulse, back porch, lines, front porch. The frame is closed by the next call's vsync fall.
    task automatic drive_frame(input int lines, input bit rand_w, input bit ramp,
                               input bit err, input bit tight, input int rst_line);
        int w;
        logic [23:0] pix;
        model_vs_fall();
        if (err) err_exp = 1;
        samp(1'b0, err, 24'($urandom));
        samp(1'b0, 1'b0, 24'($urandom));
        samp(1'b0, 1'b0, 24'($urandom));
        model_vs_rise();
        samp(1'b1, 1'b0, 24'($urandom));
        samp(1'b1, 1'b0, 24'($urandom));
        for (int l = 0; l < lines; l++) begin
            w = rand_w ? $urandom_range(1, EXP_H + 3) : EXP_H;
            for (int x = 0; x < w; x++) begin
                pix = ramp ? {8'(x), 8'(l), 8'h00} : 24'($urandom);
                if (ramp && l == 0 && x == 0) pix = 24'hFF8001;
                if (l == rst_line && x == w / 2) do_reset();
                if (in_frame && l < CAP_H && x < CAP_W) begin
                    exp_addr.push_back(l * CAP_W + x);
                    exp_data.push_back(pack(pix));
                end
                samp(1'b1, 1'b1, pix);
            end
            if (in_frame) begin
                lines_seen++;
                last_w = w;
            end
            if (!(tight && l == lines - 1)) begin
                samp(1'b1, 1'b0, 24'($urandom));
                samp(1'b1, 1'b0, 24'($urandom));
            end
        end
        if (!tight) begin
            samp(1'b1, 1'b0, 24'($urandom));
            samp(1'b1, 1'b0, 24'($urandom));
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        ce_q = 1'b0;
    int          mon_a;
    logic [14:0] mon_d;
    int          mon_v;
    int          mon_h;
    bit          mon_lk;

    always @(posedge i_clock50) ce_q <= i_ce25;

    always @(negedge i_clock50) begin
        if (i_reset_n) begin
            if (o_wren) begin
                chk("wren_after_ce", 32'(ce_q), 1);
                if (exp_addr.size() == 0) begin
                    chk("unexp_write", 32'(o_wren), 0);
                end else begin
                    mon_a = exp_addr.pop_front();
                    mon_d = exp_data.pop_front();
                    chk("wraddr", 32'(o_wraddr), 32'(mon_a));
                    chk("wrdata", 32'(o_wrdata), 32'(mon_d));
                end
            end
            if (o_frameDone) begin
                if (exp_v.size() == 0) begin
                    chk("unexp_frame", 32'(o_frameDone), 0);
                end else begin
                    mon_v  = exp_v.pop_front();
                    mon_h  = exp_h.pop_front();
                    mon_lk = exp_lk.pop_front();
                    chk("vactive", 32'(o_vActive), 32'(mon_v));
                    chk("hactive", 32'(o_hActive), 32'(mon_h));
                    chk("locked",  32'(o_locked), 32'(mon_lk));
                    chk("error_at_frame", 32'(o_error), 32'(err_exp));
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge i_clock50);
        @(negedge i_clock50);
        chk("init_wren",   32'(o_wren), 0);
        chk("init_fdone",  32'(o_frameDone), 0);
        chk("init_locked", 32'(o_locked), 0);
        chk("init_error",  32'(o_error), 0);
        chk("init_vact",   32'(o_vActive), 0);
        chk("init_hact",   32'(o_hActive), 0);
        @(posedge i_clock50); #1;
        i_reset_n = 1'b1;

        drive_frame(EXP_V,     0, 1, 0, 0, -1);   // ramp frame, first pixel FF8001
        drive_frame(EXP_V,     0, 0, 0, 0, -1);   // closes frame 1
        drive_frame(EXP_V - 1, 0, 0, 0, 0, -1);   // closes frame 2 -> locked
        drive_frame(EXP_V,     0, 0, 0, 1, -1);   // closes 479-equivalent frame -> unlocked
        drive_frame(CAP_H - 2, 1, 0, 0, 0, -1);   // closes tight frame; short frame with ragged lines
        drive_frame(EXP_V,     0, 1, 0, 0, 3);    // reset lands mid-frame
        drive_frame(EXP_V,     0, 0, 1, 0, -1);   // DE during vsync low
        chk("error_set", 32'(o_error), 1);
        drive_frame(EXP_V,     0, 0, 0, 0, -1);
        for (int i = 0; i < 4; i++) begin
            drive_frame($urandom_range(0, EXP_V + 2), 1'($urandom_range(0, 1)),
                        1'b0, 1'b0, 1'($urandom_range(0, 1)), -1);
        end
        drive_frame(0, 0, 0, 0, 0, -1);           // closes the last random frame

        @(posedge i_clock50); #1;
        i_ce25 = 1'b0;
        repeat (4) @(posedge i_clock50);
        @(negedge i_clock50);
        chk("error_sticky", 32'(o_error), 1);
        chk("writes_left",  32'(exp_addr.size()), 0);
        chk("frames_left",  32'(exp_v.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
